// File: rtl/alu_pkg.sv
// Shared types for the alu32 command issuer: opcode encoding, captured
// result record and issuer FSM states.
package alu_pkg;

   localparam int ALU_WIDTH = 32;

   typedef enum logic [2:0] {
      OP_XOR  = 3'b000,
      OP_XNOR = 3'b001,
      OP_ADD  = 3'b010,
      OP_SUB  = 3'b011,
      OP_OR   = 3'b100,
      OP_NOR  = 3'b101,
      OP_AND  = 3'b110,
      OP_ILL  = 3'b111
   } alu_op_e;

   typedef struct packed {
      logic [ALU_WIDTH-1:0] d;
      logic                 cout;
      logic                 v;
      logic                 zero;
      logic                 neg;
      logic                 err;
   } alu_res_t;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_DRIVE = 1'b1
   } issuer_state_e;

   // Result record for an illegal opcode: alu32 outputs are ignored.
   function automatic alu_res_t illegal_res();
      alu_res_t r;
      r      = alu_res_t'(0);
      r.zero = 1'b1;
      r.err  = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Result FIFO for the alu32 issuer. Storage is cleared on reset so the
// head shows all-zero fields while empty. DEPTH must be a power of two so
// the pointers wrap naturally.
module alu_res_fifo
   import alu_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = alu_res_t
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  T                             din,
   input  logic                         pop,
   output T                             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   T                mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [CW-1:0]   count_r;
   logic            pop_ok_s;

   assign pop_ok_s = pop && (count_r != CW'(0));
   assign dout     = mem_r[rd_ptr_r];
   assign count    = count_r;

   // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= T'(0);
         end
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         count_r  <= CW'(0);
      end else begin
         if (push) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push, pop_ok_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Clocked requester for the combinational alu32: registers a command onto
// the ALU inputs, holds them SETTLE cycles, captures d/Cout/V plus derived
// flags into a result FIFO.
// Optional macro ALU_STATS_EN adds saturating result/overflow counters.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int WIDTH  = ALU_WIDTH,
   parameter int SETTLE = 1,
   parameter int DEPTH  = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_a,
   input  logic [WIDTH-1:0] cmd_b,
   input  logic [2:0]       cmd_op,
   input  logic             cmd_cin,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_s,
   output logic             alu_cin,
   input  logic [WIDTH-1:0] alu_d,
   input  logic             alu_cout,
   input  logic             alu_v,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_d,
   output logic             res_cout,
   output logic             res_v,
   output logic             res_zero,
   output logic             res_neg,
   output logic             res_err
`ifdef ALU_STATS_EN
   ,
   input  logic             stat_clr,
   output logic [15:0]      stat_ops,
   output logic [15:0]      stat_ovf
`endif
);

   localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int CW = $clog2(DEPTH+1);

   issuer_state_e    state_r;
   issuer_state_e    state_nxt_s;
   logic [SW-1:0]    settle_cnt_r;
   logic [WIDTH-1:0] alu_a_r;
   logic [WIDTH-1:0] alu_b_r;
   logic [2:0]       alu_s_r;
   logic             alu_cin_r;
   logic             cmd_ready_s;
   logic             accept_s;
   logic             push_s;
   logic             pop_s;
   logic [CW-1:0]    count_s;
   alu_res_t         cap_s;
   alu_res_t         head_s;

   assign accept_s = cmd_valid && cmd_ready_s;
   assign pop_s    = res_valid && res_ready;

   // Next-state, handshake and push decode; only one command is ever in flight.
   always_comb begin
      state_nxt_s = state_r;
      cmd_ready_s = 1'b0;
      push_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin
            cmd_ready_s = (count_s < CW'(DEPTH));
            if (cmd_valid && cmd_ready_s) begin
               state_nxt_s = ST_DRIVE;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_DRIVE: begin
            if (settle_cnt_r == SW'(0)) begin
               push_s      = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DRIVE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State, settle counter and held ALU operands; operands persist between commands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         settle_cnt_r <= SW'(0);
         alu_a_r      <= WIDTH'(0);
         alu_b_r      <= WIDTH'(0);
         alu_s_r      <= 3'b000;
         alu_cin_r    <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         if (accept_s) begin
            alu_a_r      <= cmd_a;
            alu_b_r      <= cmd_b;
            alu_s_r      <= cmd_op;
            alu_cin_r    <= cmd_cin;
            settle_cnt_r <= SW'(SETTLE - 1);
         end else if ((state_r == ST_DRIVE) && (settle_cnt_r != SW'(0))) begin
            settle_cnt_r <= settle_cnt_r - SW'(1);
         end else begin
            settle_cnt_r <= settle_cnt_r;
         end
      end
   end

   // Build the result record from the settled ALU outputs; illegal ops ignore them.
   always_comb begin
      cap_s = alu_res_t'(0);
      if (alu_s_r == OP_ILL) begin
         cap_s = illegal_res();
      end else begin
         cap_s.d    = alu_d;
         cap_s.cout = alu_cout;
         cap_s.v    = alu_v;
         cap_s.zero = (alu_d == WIDTH'(0));
         cap_s.neg  = alu_d[WIDTH-1];
         cap_s.err  = 1'b0;
      end
   end

   alu_res_fifo #(
      .DEPTH (DEPTH),
      .T     (alu_res_t)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .din   (cap_s),
      .pop   (pop_s),
      .dout  (head_s),
      .count (count_s)
   );

   assign cmd_ready = cmd_ready_s;
   assign alu_a     = alu_a_r;
   assign alu_b     = alu_b_r;
   assign alu_s     = alu_s_r;
   assign alu_cin   = alu_cin_r;
   assign res_valid = (count_s != CW'(0));
   assign res_d     = head_s.d;
   assign res_cout  = head_s.cout;
   assign res_v     = head_s.v;
   assign res_zero  = head_s.zero;
   assign res_neg   = head_s.neg;
   assign res_err   = head_s.err;

`ifdef ALU_STATS_EN
   logic [15:0] stat_ops_r;
   logic [15:0] stat_ovf_r;

   // Saturating counters of pushed results and overflowing results; clear wins.
   always_ff @(posedge clk) begin
      if (!rst_n || stat_clr) begin
         stat_ops_r <= 16'h0000;
         stat_ovf_r <= 16'h0000;
      end else if (push_s) begin
         if (stat_ops_r != 16'hFFFF) begin
            stat_ops_r <= stat_ops_r + 16'h0001;
         end
         if (cap_s.v && (stat_ovf_r != 16'hFFFF)) begin
            stat_ovf_r <= stat_ovf_r + 16'h0001;
         end
      end else begin
         stat_ops_r <= stat_ops_r;
         stat_ovf_r <= stat_ovf_r;
      end
   end

   assign stat_ops = stat_ops_r;
   assign stat_ovf = stat_ovf_r;
`endif

endmodule
